// File: rtl/sc_ifu_if.sv
// Bus between the instruction fetch unit and its control unit / instruction memory.
// The master modport is the fetch unit's own view of the bus.
interface sc_ifu_if;
    logic [1:0]  pcsource;
    logic [31:0] ra;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        inst_valid;
    logic        halted;
    logic [1:0]  err;
    logic [31:0] icount;

    modport master (
        input  pcsource, ra, stall, imem_rdata, imem_ack,
        output imem_req, imem_addr, inst, pc, pc4, inst_valid, halted, err, icount
    );

    modport slave (
        output pcsource, ra, stall, imem_rdata, imem_ack,
        input  imem_req, imem_addr, inst, pc, pc4, inst_valid, halted, err, icount
    );
endinterface

// File: rtl/sc_ifu.sv
// Instruction fetch unit: fetches a word from imem, holds it for execute, then selects
// the next PC. Fetch timeouts and misaligned targets park the unit in a sticky halt.
module sc_ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input logic      clock,
    input logic      resetn,
    sc_ifu_if.master bus
);
    typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

    localparam logic [1:0] ErrTimeout = 2'b01;
    localparam logic [1:0] ErrAlign   = 2'b10;
    localparam logic [7:0] WaitLast   = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] icount_q, icount_d;
    logic [1:0]  err_q, err_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic [31:0] npc;

    assign pc_plus4 = pc_q + 32'd4;
    assign br_off   = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

    always_comb begin
        case (bus.pcsource)
            2'b00:   npc = pc_plus4;
            2'b01:   npc = pc_plus4 + br_off;
            2'b10:   npc = bus.ra;
            default: npc = {pc_plus4[31:28], inst_q[25:0], 2'b00};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        icount_d = icount_q;
        err_d    = err_q;
        wait_d   = wait_q;
        case (state_q)
            StIdle: begin
                state_d = StFetch;
                wait_d  = '0;
            end
            StFetch: begin
                // An ack in the last allowed cycle still wins over the timeout.
                if (bus.imem_ack) begin
                    inst_d  = bus.imem_rdata;
                    state_d = StExec;
                end else if (wait_q == WaitLast) begin
                    state_d = StHalt;
                    err_d   = ErrTimeout;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StExec: begin
                if (!bus.stall) begin
                    if (npc[1:0] != 2'b00) begin
                        state_d = StHalt;
                        err_d   = ErrAlign;
                    end else begin
                        pc_d     = npc;
                        icount_d = icount_q + 32'd1;
                        state_d  = StFetch;
                        wait_d   = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            inst_q   <= '0;
            icount_q <= '0;
            err_q    <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            icount_q <= icount_d;
            err_q    <= err_d;
            wait_q   <= wait_d;
        end
    end

    // Handshake outputs come from state alone so no input reaches them combinationally.
    assign bus.imem_req   = (state_q == StFetch);
    assign bus.inst_valid = (state_q == StExec);
    assign bus.halted     = (state_q == StHalt);
    assign bus.imem_addr  = pc_q;
    assign bus.pc         = pc_q;
    assign bus.pc4        = pc_plus4;
    assign bus.inst       = inst_q;
    assign bus.err        = err_q;
    assign bus.icount     = icount_q;
endmodule
